hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Parametrised successor to the single-cycle hazard unit. Adds a register scoreboard for long-latency writers (divider, multi-cycle loads) so independent instructions keep flowing past a busy unit.
- Sits beside the 5-stage pipeline. Generates per-stage stall/flush, tracks outstanding long ops, handles load-use, redirects and memory freezes, and keeps hazard performance counters.

Parameters:
- NUM_REGS, 32, architectural registers; x0 is never tracked.
- ADDR_W, $clog2(NUM_REGS), register address width.
- MAX_OUTSTANDING, 4, maximum in-flight long-latency ops (>=1).
- FLUSH_STAGES, 2, younger stages squashed on redirect (1 = IF/ID only, 2 = IF/ID and ID/EX).
- PERF_W, 32, performance counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_id_rs1_addr, if_id_rs2_addr, if_id_rd_addr  in  ADDR_W  operands and destination of the instruction in ID
- if_id_valid  in  1  ID holds a real instruction
- id_ex_valid, id_ex_mem_read, id_ex_reg_write  in  1  EX-stage instruction attributes
- id_ex_long_op  in  1  EX instruction retires through the long-latency path
- id_ex_rd_addr  in  ADDR_W  EX destination
- long_done_valid  in  1  a long op writes back this cycle
- long_done_rd  in  ADDR_W  its destination
- mem_busy  in  1  data memory not ready; freeze the pipeline
- branch_taken  in  1  redirect from EX
- pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush  out  1  stage controls
- sb_busy  out  NUM_REGS  scoreboard bit per register
- sb_full  out  1  outstanding count == MAX_OUTSTANDING
- perf_stall_cycles, perf_flush_events  out  PERF_W  counters

Behaviour:
- One clock `clk`; reset `rst` is synchronous and active-high. On reset, sb_busy = 0, outstanding count = 0, perf counters = 0.
- All stage-control outputs are combinational. Scoreboard and counters update on the clk rising edge.
- Combinational hazard terms:
  - raw_sb: if_id_valid and a non-zero rs1/rs2 has its sb_busy bit set.
  - waw_sb: if_id_valid, non-zero rd, and sb_busy[rd] set.
  - load_use: id_ex_valid, id_ex_mem_read, not id_ex_long_op, rd != 0, and rd matches a non-zero rs1/rs2.
  - issue_full: id_ex_valid, id_ex_long_op, and sb_full.
- Priority, highest first:
  1. mem_busy: every *_stall and pc_stall = 1; no flush.
  2. branch_taken: if_id_flush = 1; id_ex_flush = 1 only when FLUSH_STAGES >= 2; no stalls.
  3. issue_full: pc/if_id/id_ex stall; ex_mem_flush = 1 (bubble).
  4. raw_sb, waw_sb or load_use: pc/if_id stall; id_ex_flush = 1.
  5. Otherwise all outputs are 0.
- Scoreboard set: id_ex_valid, id_ex_long_op, id_ex_reg_write, rd != 0, no mem_busy and no issue_full set sb_busy[rd] at the edge and increment the count.
  - The EX instruction is older than the branch, so branch_taken does not block the set.
- Scoreboard clear: long_done_valid clears sb_busy[long_done_rd] and decrements the count.
  - Clear of a non-busy bit or of x0 is ignored, and the count does not change.
- Set and clear in the same cycle:
  - Same register: the bit stays 1 and the count is unchanged.
  - Different registers: both take effect and the count is unchanged.
- Count is clamped to the range 0..MAX_OUTSTANDING and never wraps.
- perf_stall_cycles increments each cycle pc_stall = 1. perf_flush_events increments each cycle branch_taken wins arbitration. Both saturate at all-ones.
- rst during an active stall drops all outputs to 0 in the cycle after it is sampled.

Decomposition:
- riscv_pkg gains hazard_cause_t enum (NONE, MEM_FREEZE, REDIRECT, SB_FULL, RAW, LOAD_USE) and the default constants MAX_OUTSTANDING and FLUSH_STAGES.
- One sub-module, hazard_scoreboard: busy vector, outstanding count, set/clear logic.
- Arbitration and perf counters stay in the top module.

Test Plan:
- Divide to x5 issued, then add reading x5 in ID → pc/if_id stall and id_ex_flush until long_done_rd=5; sb_busy[5] stays 1 for that whole span; perf_stall_cycles equals the stall length.
- Divide to x5, then independent add x6 ← x7+x8 → no stall, sb_busy = 0x20.
- Four divides to x1..x4 with MAX_OUTSTANDING=4, then a fifth to x9 → sb_full=1 and issue stall; a completion for x2 releases it the next cycle.
- Load to x3 (non-long) with ID using x3 → one-cycle stall and id_ex_flush; with rs=x0 instead → no stall.
- branch_taken together with raw_sb and mem_busy → freeze wins; after mem_busy drops, flush wins. With FLUSH_STAGES=1, id_ex_flush=0.
- Set and clear of x7 in the same cycle → sb_busy[7]=1 and count unchanged; clear of x0 or an idle register → no change; rst mid-stall → all outputs 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared hazard-unit types and default sizing constants
package riscv_pkg;

    typedef enum logic [2:0] {
        NONE,
        MEM_FREEZE,
        REDIRECT,
        SB_FULL,
        RAW,
        LOAD_USE
    } hazard_cause_t;

    localparam int DEFAULT_MAX_OUTSTANDING = 4;
    localparam int DEFAULT_FLUSH_STAGES    = 2;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - busy bit per register plus clamped in-flight long-op count
module hazard_scoreboard
    import riscv_pkg::*;
#(
    parameter int NUM_REGS        = 32,
    parameter int ADDR_W          = $clog2(NUM_REGS),
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_set_en,
    input  logic [ADDR_W-1:0]   i_set_rd,
    input  logic                i_clr_en,
    input  logic [ADDR_W-1:0]   i_clr_rd,
    output logic [NUM_REGS-1:0] o_busy,
    output logic                o_full
);

    logic [NUM_REGS-1:0] r_busy;
    logic [CNT_W-1:0]    r_count;
    logic                w_set;
    logic                w_clr;
    logic                w_inc;
    logic                w_dec;

    // Clears only count when they retire a tracked op; x0 is never tracked.
    assign w_set = i_set_en && (i_set_rd != '0);
    assign w_clr = i_clr_en && (i_clr_rd != '0) && r_busy[i_clr_rd];
    assign w_inc = w_set && !w_clr;
    assign w_dec = w_clr && !w_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            // Set is applied last so a same-register set/clear leaves the bit busy.
            if (w_clr) r_busy[i_clr_rd] <= 1'b0;
            if (w_set) r_busy[i_set_rd] <= 1'b1;
            if (w_inc && (r_count != CNT_W'(MAX_OUTSTANDING)))
                r_count <= r_count + 1'b1;
            else if (w_dec && (r_count != '0))
                r_count <= r_count - 1'b1;
        end
    end

    assign o_busy = r_busy;
    assign o_full = (r_count == CNT_W'(MAX_OUTSTANDING));

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard arbitration, scoreboard hookup and perf counters
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int NUM_REGS        = 32,
    parameter int ADDR_W          = $clog2(NUM_REGS),
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
    parameter int FLUSH_STAGES    = DEFAULT_FLUSH_STAGES,
    parameter int PERF_W          = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   if_id_rs1_addr,
    input  logic [ADDR_W-1:0]   if_id_rs2_addr,
    input  logic [ADDR_W-1:0]   if_id_rd_addr,
    input  logic                if_id_valid,
    input  logic                id_ex_valid,
    input  logic                id_ex_mem_read,
    input  logic                id_ex_reg_write,
    input  logic                id_ex_long_op,
    input  logic [ADDR_W-1:0]   id_ex_rd_addr,
    input  logic                long_done_valid,
    input  logic [ADDR_W-1:0]   long_done_rd,
    input  logic                mem_busy,
    input  logic                branch_taken,
    output logic                pc_stall,
    output logic                if_id_stall,
    output logic                if_id_flush,
    output logic                id_ex_stall,
    output logic                id_ex_flush,
    output logic                ex_mem_stall,
    output logic                ex_mem_flush,
    output logic                mem_wb_stall,
    output logic                mem_wb_flush,
    output logic [NUM_REGS-1:0] sb_busy,
    output logic                sb_full,
    output logic [PERF_W-1:0]   perf_stall_cycles,
    output logic [PERF_W-1:0]   perf_flush_events
);

    localparam bit FLUSH_EX_ON_REDIRECT = (FLUSH_STAGES >= 2);

    logic          w_raw_sb;
    logic          w_waw_sb;
    logic          w_load_use;
    logic          w_issue_full;
    logic          w_sb_set;
    hazard_cause_t w_cause;
    logic [PERF_W-1:0] r_stall_cycles;
    logic [PERF_W-1:0] r_flush_events;

    assign w_raw_sb = if_id_valid &&
        (((if_id_rs1_addr != '0) && sb_busy[if_id_rs1_addr]) ||
         ((if_id_rs2_addr != '0) && sb_busy[if_id_rs2_addr]));
    assign w_waw_sb = if_id_valid && (if_id_rd_addr != '0) && sb_busy[if_id_rd_addr];
    assign w_load_use = id_ex_valid && id_ex_mem_read && !id_ex_long_op &&
        (id_ex_rd_addr != '0) &&
        ((id_ex_rd_addr == if_id_rs1_addr) || (id_ex_rd_addr == if_id_rs2_addr));
    assign w_issue_full = id_ex_valid && id_ex_long_op && sb_full;

    // The EX instruction is older than a redirect, so only a freeze or a full table blocks issue.
    assign w_sb_set = id_ex_valid && id_ex_long_op && id_ex_reg_write &&
                      !mem_busy && !w_issue_full;

    hazard_scoreboard #(
        .NUM_REGS        (NUM_REGS),
        .ADDR_W          (ADDR_W),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .i_set_en (w_sb_set),
        .i_set_rd (id_ex_rd_addr),
        .i_clr_en (long_done_valid),
        .i_clr_rd (long_done_rd),
        .o_busy   (sb_busy),
        .o_full   (sb_full)
    );

    always_comb begin
        w_cause = NONE;
        if (mem_busy)                  w_cause = MEM_FREEZE;
        else if (branch_taken)         w_cause = REDIRECT;
        else if (w_issue_full)         w_cause = SB_FULL;
        else if (w_raw_sb || w_waw_sb) w_cause = RAW;
        else if (w_load_use)           w_cause = LOAD_USE;
    end

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_stall = 1'b0;
        mem_wb_flush = 1'b0;
        case (w_cause)
            MEM_FREEZE: begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_stall = 1'b1;
            end
            REDIRECT: begin
                if_id_flush = 1'b1;
                id_ex_flush = FLUSH_EX_ON_REDIRECT;
            end
            SB_FULL: begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
            end
            RAW, LOAD_USE: begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (pc_stall && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if ((w_cause == REDIRECT) && (r_flush_events != '1))
                r_flush_events <= r_flush_events + 1'b1;
        end
    end

    assign perf_stall_cycles = r_stall_cycles;
    assign perf_flush_events = r_flush_events;

endmodule
